// File: rtl/rf_pkg.sv
// Shared types and defaults for the multiport register file and its dump engine.
package rf_pkg;

  localparam int RF_XLEN  = 32;
  localparam int RF_DEPTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } dump_state_t;

endpackage

// File: rtl/regfile_dump_ctrl.sv
// Serial dump engine: walks register indices 0..DEPTH-1, one word per two cycles at best.
// Each word is snapshotted in LOAD and then held in SEND until the valid/ready handshake.
module regfile_dump_ctrl
  import rf_pkg::*;
#(
  parameter int XLEN  = RF_XLEN,
  parameter int DEPTH = RF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_ready,
  input  logic [XLEN-1:0]   i_rdata,
  output logic [ADDR_W-1:0] o_ridx,
  output logic              o_busy,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_idx,
  output logic [XLEN-1:0]   o_data,
  output logic              o_last
);

  dump_state_t       r_state;
  logic              r_busy;
  logic              r_valid;
  logic [ADDR_W-1:0] r_idx;
  logic [XLEN-1:0]   r_data;
  logic              w_at_end;

  assign w_at_end = (r_idx == ADDR_W'(DEPTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_data  <= i_rdata;
          r_valid <= 1'b1;
          r_state <= ST_SEND;
        end
        ST_SEND: begin
          if (i_ready) begin
            r_valid <= 1'b0;
            if (w_at_end) begin
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= ST_LOAD;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_ridx  = r_idx;
  assign o_busy  = r_busy;
  assign o_valid = r_valid;
  assign o_idx   = r_idx;
  assign o_data  = r_data;
  assign o_last  = r_valid && w_at_end;

endmodule

// File: rtl/regfile_multiport.sv
// Integer register file: NUM_RD registered read ports (write-first bypass), one write port, x0 = 0.
// Read latency 1; the dump stream stalls only on its own ready, never the read/write ports.
module regfile_multiport
  import rf_pkg::*;
#(
  parameter int          XLEN    = RF_XLEN,
  parameter int          DEPTH   = RF_DEPTH,
  parameter int          NUM_RD  = 2,
  parameter int          RST_IDX = 29,
  parameter int unsigned RST_VAL = 252,
  parameter int          ADDR_W  = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*XLEN-1:0]   rd_data,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [XLEN-1:0]          wr_data,
  input  logic                     dump_start,
  output logic                     dump_busy,
  output logic                     dump_valid,
  input  logic                     dump_ready,
  output logic [ADDR_W-1:0]        dump_idx,
  output logic [XLEN-1:0]          dump_data,
  output logic                     dump_last
);

  logic [XLEN-1:0]   r_regs [DEPTH];
  logic [ADDR_W-1:0] w_dump_ridx;
  logic [XLEN-1:0]   w_dump_rdata;

  // x0 is only ever loaded by reset, so it stays zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        r_regs[i] <= ((RST_IDX != 0) && (i == RST_IDX)) ? XLEN'(RST_VAL) : '0;
    end else if (wr_en && (wr_addr != '0)) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic [XLEN-1:0]   r_q;

    assign w_addr = rd_addr[g*ADDR_W +: ADDR_W];

    always_ff @(posedge clk or posedge reset) begin
      if (reset)
        r_q <= '0;
      else if (w_addr == '0)
        r_q <= '0;
      else if (wr_en && (wr_addr == w_addr))
        r_q <= wr_data;
      else
        r_q <= r_regs[w_addr];
    end

    assign rd_data[g*XLEN +: XLEN] = r_q;
  end

  assign w_dump_rdata = (w_dump_ridx == '0)                   ? '0      :
                        (wr_en && (wr_addr == w_dump_ridx))   ? wr_data :
                                                                r_regs[w_dump_ridx];

  regfile_dump_ctrl #(
    .XLEN   (XLEN),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_dump (
    .clk     (clk),
    .reset   (reset),
    .i_start (dump_start),
    .i_ready (dump_ready),
    .i_rdata (w_dump_rdata),
    .o_ridx  (w_dump_ridx),
    .o_busy  (dump_busy),
    .o_valid (dump_valid),
    .o_idx   (dump_idx),
    .o_data  (dump_data),
    .o_last  (dump_last)
  );

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport: inputs driven and outputs sampled on the falling edge.
module tb_regfile_multiport;

  localparam int XLEN   = 32;
  localparam int DEPTH  = 32;
  localparam int NUM_RD = 2;
  localparam int AW     = 5;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NUM_RD*AW-1:0]   rd_addr;
  logic [NUM_RD*XLEN-1:0] rd_data;
  logic                   wr_en;
  logic [AW-1:0]          wr_addr;
  logic [XLEN-1:0]        wr_data;
  logic                   dump_start;
  logic                   dump_busy;
  logic                   dump_valid;
  logic                   dump_ready;
  logic [AW-1:0]          dump_idx;
  logic [XLEN-1:0]        dump_data;
  logic                   dump_last;
  logic [XLEN-1:0]        rd0;
  logic [XLEN-1:0]        rd1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign rd0 = rd_data[XLEN-1:0];
  assign rd1 = rd_data[2*XLEN-1:XLEN];

  regfile_multiport #(
    .XLEN(XLEN), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .RST_IDX(29), .RST_VAL(252)
  ) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data),
    .dump_last(dump_last)
  );

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic write_reg(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic start_dump();
    dump_ready = 1'b1; dump_start = 1'b1;
    @(negedge clk);
    dump_start = 1'b0;
  endtask

  task automatic test_reset();
    write_reg(5'd3, 32'h55);
    set_rd(5'd3, 5'd29);
    @(negedge clk);
    n_checks++;
    if (rd0 !== 32'h55) begin n_fail++; $display("FAIL pre_reset_rd0: got %h want %h", rd0, 32'h55); end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (rd_data !== '0) begin n_fail++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
    n_checks++;
    if ({dump_busy, dump_valid, dump_last, dump_idx, dump_data} !== '0) begin
      n_fail++; $display("FAIL reset_dump_outs: busy=%b valid=%b last=%b idx=%0d data=%h want all 0",
                         dump_busy, dump_valid, dump_last, dump_idx, dump_data);
    end
    @(negedge clk);
    reset = 1'b0;
    set_rd(5'd29, 5'd1);
    @(negedge clk);
    n_checks++;
    if (rd0 !== 32'd252) begin n_fail++; $display("FAIL reset_x29: got %0d want 252", rd0); end
    n_checks++;
    if (rd1 !== 32'd0) begin n_fail++; $display("FAIL reset_x1: got %h want 0", rd1); end
    set_rd(5'd3, 5'd29);
    @(negedge clk);
    n_checks++;
    if ({rd1, rd0} !== {32'd252, 32'd0}) begin
      n_fail++; $display("FAIL reset_x3_x29: got rd0=%h rd1=%h want 0 / fc", rd0, rd1);
    end
  endtask

  task automatic test_x0();
    set_rd(5'd0, 5'd0);
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hDEADBEEF;
    @(negedge clk);
    wr_en = 1'b0;
    n_checks++;
    if (rd_data !== '0) begin n_fail++; $display("FAIL x0_same_edge: got %h want 0", rd_data); end
    @(negedge clk);
    n_checks++;
    if (rd_data !== '0) begin n_fail++; $display("FAIL x0_after_write: got %h want 0", rd_data); end
  endtask

  task automatic test_bypass();
    write_reg(5'd6, 32'h66);
    write_reg(5'd5, 32'h55);
    set_rd(5'd5, 5'd6);
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h1234;
    @(negedge clk);
    wr_en = 1'b0;
    n_checks++;
    if (rd0 !== 32'h1234) begin n_fail++; $display("FAIL bypass_rd0: got %h want 1234", rd0); end
    n_checks++;
    if (rd1 !== 32'h66) begin n_fail++; $display("FAIL bypass_rd1: got %h want 66", rd1); end
    @(negedge clk);
    n_checks++;
    if (rd0 !== 32'h1234) begin n_fail++; $display("FAIL bypass_stored: got %h want 1234", rd0); end
  endtask

  task automatic test_dump_ready();
    int nwords;
    int nbusy;
    for (int i = 1; i < DEPTH; i++) write_reg(AW'(i), XLEN'(i * 3));
    start_dump();
    nwords = 0;
    nbusy  = 0;
    for (int c = 0; c < 200 && dump_busy; c++) begin
      nbusy++;
      if (dump_valid) begin
        n_checks++;
        if ({dump_idx, dump_data, dump_last} !== {AW'(nwords), XLEN'(nwords * 3), (nwords == 31)}) begin
          n_fail++; $display("FAIL dump_word%0d: got idx=%0d data=%0d last=%b want idx=%0d data=%0d last=%b",
                             nwords, dump_idx, dump_data, dump_last, nwords, nwords * 3, nwords == 31);
        end
        nwords++;
      end
      @(negedge clk);
    end
    n_checks++;
    if (nwords != 32) begin n_fail++; $display("FAIL dump_count: got %0d words want 32", nwords); end
    n_checks++;
    if (nbusy != 64) begin n_fail++; $display("FAIL dump_busy_cycles: got %0d want 64", nbusy); end
    n_checks++;
    if ({dump_busy, dump_valid} !== 2'b00) begin
      n_fail++; $display("FAIL dump_idle_after: busy=%b valid=%b want 0 0", dump_busy, dump_valid);
    end
  endtask

  task automatic test_backpressure();
    start_dump();
    for (int c = 0; c < 100 && !(dump_busy && !dump_valid && dump_idx == 5'd7); c++) @(negedge clk);
    n_checks++;
    if (!(dump_busy && !dump_valid && dump_idx == 5'd7)) begin
      n_fail++; $display("FAIL bp_reach_idx7: idx=%0d busy=%b want idx 7 in load", dump_idx, dump_busy);
    end
    dump_ready = 1'b0;
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hAA;
    for (int s = 0; s < 5; s++) begin
      n_checks++;
      if ({dump_valid, dump_idx, dump_data} !== {1'b1, 5'd7, 32'd21}) begin
        n_fail++; $display("FAIL bp_hold%0d: valid=%b idx=%0d data=%h want 1 7 15", s, dump_valid, dump_idx, dump_data);
      end
      @(negedge clk);
      wr_en = 1'b0;
    end
    dump_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({dump_valid, dump_idx} !== {1'b0, 5'd8}) begin
      n_fail++; $display("FAIL bp_advance: valid=%b idx=%0d want 0 8", dump_valid, dump_idx);
    end
    @(negedge clk);
    n_checks++;
    if ({dump_valid, dump_idx, dump_data} !== {1'b1, 5'd8, 32'd24}) begin
      n_fail++; $display("FAIL bp_next_word: valid=%b idx=%0d data=%0d want 1 8 24", dump_valid, dump_idx, dump_data);
    end
    for (int c = 0; c < 100 && dump_busy; c++) @(negedge clk);
    n_checks++;
    if (dump_busy !== 1'b0) begin n_fail++; $display("FAIL bp_finish: busy=%b want 0", dump_busy); end
    set_rd(5'd7, 5'd8);
    @(negedge clk);
    n_checks++;
    if ({rd1, rd0} !== {32'd24, 32'hAA}) begin
      n_fail++; $display("FAIL bp_x7_written: rd0=%h rd1=%h want aa 18", rd0, rd1);
    end
  endtask

  task automatic test_abort();
    logic [AW-1:0] prev;
    bit            mono;
    bit            pulsed;
    bit            quiet;
    start_dump();
    prev = '0; mono = 1'b1; pulsed = 1'b0;
    for (int c = 0; c < 100 && !(dump_busy && dump_idx == 5'd12); c++) begin
      if (dump_idx < prev) mono = 1'b0;
      prev = dump_idx;
      if (dump_idx == 5'd3 && !pulsed) begin
        dump_start = 1'b1; pulsed = 1'b1;
      end else begin
        dump_start = 1'b0;
      end
      @(negedge clk);
    end
    dump_start = 1'b0;
    n_checks++;
    if (!(mono && pulsed && dump_busy && dump_idx == 5'd12)) begin
      n_fail++; $display("FAIL abort_no_restart: mono=%b pulsed=%b busy=%b idx=%0d want 1 1 1 12",
                         mono, pulsed, dump_busy, dump_idx);
    end
    @(negedge clk);
    n_checks++;
    if ({dump_valid, dump_idx, dump_data} !== {1'b1, 5'd12, 32'd36}) begin
      n_fail++; $display("FAIL abort_pre: valid=%b idx=%0d data=%0d want 1 12 36", dump_valid, dump_idx, dump_data);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({dump_busy, dump_valid, dump_last, dump_idx, dump_data} !== '0) begin
      n_fail++; $display("FAIL abort_reset: busy=%b valid=%b idx=%0d data=%h want all 0",
                         dump_busy, dump_valid, dump_idx, dump_data);
    end
    @(negedge clk);
    reset = 1'b0;
    quiet = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (dump_valid || dump_busy) quiet = 1'b0;
    end
    n_checks++;
    if (!quiet) begin n_fail++; $display("FAIL abort_quiet: got words after reset, want none"); end
    set_rd(5'd7, 5'd29);
    @(negedge clk);
    n_checks++;
    if ({rd1, rd0} !== {32'd252, 32'd0}) begin
      n_fail++; $display("FAIL abort_regs_a: rd0=%h rd1=%h want 0 fc", rd0, rd1);
    end
    set_rd(5'd5, 5'd31);
    @(negedge clk);
    n_checks++;
    if (rd_data !== '0) begin n_fail++; $display("FAIL abort_regs_b: got %h want 0", rd_data); end
  endtask

  initial begin
    reset = 1'b1; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    dump_start = 1'b0; dump_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_x0();
    test_bypass();
    test_dump_ready();
    test_backpressure();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
